// File: rtl/bpu_es_resolver_if.sv
// Lane inputs and BPU-facing results of the EXE-stage branch resolver.
// slave is the resolver's view; master is the EXE pipeline / BPU side.
interface bpu_es_resolver_if #(
  parameter int EPOCH_W = 2,
  parameter int CNT_W   = 32
);
  logic               es_stall;

  logic               l1_valid;
  logic [31:0]        l1_pc;
  logic               l1_is_br;
  logic               l1_taken;
  logic [31:0]        l1_target;
  logic [1:0]         l1_jtype;
  logic               l1_excp;
  logic               l1_etrn;
  logic               l1_pred_taken;
  logic [31:0]        l1_pred_target;
  logic [EPOCH_W-1:0] l1_epoch;

  logic               l2_valid;
  logic [31:0]        l2_pc;
  logic               l2_is_br;
  logic               l2_taken;
  logic [31:0]        l2_target;
  logic [1:0]         l2_jtype;
  logic               l2_excp;
  logic               l2_etrn;
  logic               l2_pred_taken;
  logic [31:0]        l2_pred_target;
  logic [EPOCH_W-1:0] l2_epoch;

  logic [71:0]        bpu_es_bus1;
  logic [71:0]        bpu_es_bus2;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [EPOCH_W-1:0] cur_epoch;
  logic [CNT_W-1:0]   cnt_branch;
  logic [CNT_W-1:0]   cnt_mispred;

  modport slave (
    input  es_stall,
    input  l1_valid, l1_pc, l1_is_br, l1_taken, l1_target, l1_jtype,
           l1_excp, l1_etrn, l1_pred_taken, l1_pred_target, l1_epoch,
    input  l2_valid, l2_pc, l2_is_br, l2_taken, l2_target, l2_jtype,
           l2_excp, l2_etrn, l2_pred_taken, l2_pred_target, l2_epoch,
    output bpu_es_bus1, bpu_es_bus2, redirect, redirect_pc, cur_epoch,
           cnt_branch, cnt_mispred
  );

  modport master (
    output es_stall,
    output l1_valid, l1_pc, l1_is_br, l1_taken, l1_target, l1_jtype,
           l1_excp, l1_etrn, l1_pred_taken, l1_pred_target, l1_epoch,
    output l2_valid, l2_pc, l2_is_br, l2_taken, l2_target, l2_jtype,
           l2_excp, l2_etrn, l2_pred_taken, l2_pred_target, l2_epoch,
    input  bpu_es_bus1, bpu_es_bus2, redirect, redirect_pc, cur_epoch,
           cnt_branch, cnt_mispred
  );
endinterface

// File: rtl/bpu_es_resolver.sv
// EXE-stage branch resolver: checks two lanes against IF predictions, drives
// BPU update words, a single redirect, a flush epoch and saturating counters.
module bpu_es_resolver #(
  parameter int EPOCH_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  bpu_es_resolver_if.slave   es
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic mispredict(input logic        br,
                                      input logic        taken,
                                      input logic        pred_taken,
                                      input logic [31:0] target,
                                      input logic [31:0] pred_target);
    return br && ((taken != pred_taken) || (taken && (target != pred_target)));
  endfunction

  logic [71:0]        r_bus1_p1;
  logic [71:0]        r_bus2_p1;
  logic               r_redir_vld_p1;
  logic [31:0]        r_redir_pc_p1;
  logic [EPOCH_W-1:0] r_epoch;
  logic [CNT_W-1:0]   r_cnt_branch;
  logic [CNT_W-1:0]   r_cnt_mispred;

  logic        w_live1_p0, w_live2_p0;
  logic        w_br1_p0, w_br2_p0;
  logic        w_mis1_p0, w_mis2_p0;
  logic        w_redir_vld_p0;
  logic [31:0] w_next1_p0, w_next2_p0, w_redir_pc_p0;
  logic [71:0] w_bus1_p0, w_bus2_p0;
  logic [1:0]  w_nbr_p0;

  // ---- stage p0: liveness, resolution, bus word assembly
  assign w_live1_p0 = es.l1_valid && !es.es_stall && (es.l1_epoch == r_epoch);
  assign w_br1_p0   = w_live1_p0 && es.l1_is_br && !es.l1_excp && !es.l1_etrn;
  assign w_mis1_p0  = mispredict(w_br1_p0, es.l1_taken, es.l1_pred_taken,
                                 es.l1_target, es.l1_pred_target);

  // An older-lane mispredict makes lane2 wrong-path: it is squashed outright.
  assign w_live2_p0 = es.l2_valid && !es.es_stall && (es.l2_epoch == r_epoch) && !w_mis1_p0;
  assign w_br2_p0   = w_live2_p0 && es.l2_is_br && !es.l2_excp && !es.l2_etrn;
  assign w_mis2_p0  = mispredict(w_br2_p0, es.l2_taken, es.l2_pred_taken,
                                 es.l2_target, es.l2_pred_target);

  assign w_next1_p0 = es.l1_taken ? es.l1_target : es.l1_pc + 32'd4;
  assign w_next2_p0 = es.l2_taken ? es.l2_target : es.l2_pc + 32'd4;

  assign w_redir_vld_p0 = w_mis1_p0 || w_mis2_p0;
  assign w_redir_pc_p0  = w_mis1_p0 ? w_next1_p0 : w_next2_p0;
  assign w_nbr_p0       = {1'b0, w_br1_p0} + {1'b0, w_br2_p0};

  assign w_bus1_p0 = w_live1_p0 ?
      {w_mis1_p0, es.l1_excp, es.l1_etrn, es.l1_pc, es.l1_is_br, es.l1_taken,
       w_mis1_p0, es.l1_target, es.l1_jtype} : 72'd0;
  assign w_bus2_p0 = w_live2_p0 ?
      {w_mis2_p0, es.l2_excp, es.l2_etrn, es.l2_pc, es.l2_is_br, es.l2_taken,
       w_mis2_p0, es.l2_target, es.l2_jtype} : 72'd0;

  // ---- stage p1: registered outputs and architectural state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus1_p1      <= 72'd0;
      r_bus2_p1      <= 72'd0;
      r_redir_vld_p1 <= 1'b0;
      r_redir_pc_p1  <= 32'd0;
      r_epoch        <= '0;
      r_cnt_branch   <= '0;
      r_cnt_mispred  <= '0;
    end else begin
      r_bus1_p1      <= w_bus1_p0;
      r_bus2_p1      <= w_bus2_p0;
      r_redir_vld_p1 <= w_redir_vld_p0;
      r_cnt_branch   <= sat_add(r_cnt_branch, w_nbr_p0);
      r_cnt_mispred  <= sat_add(r_cnt_mispred, {1'b0, w_redir_vld_p0});
      if (w_redir_vld_p0) begin
        r_redir_pc_p1 <= w_redir_pc_p0;
        r_epoch       <= r_epoch + EPOCH_W'(1);
      end
    end
  end

  assign es.bpu_es_bus1 = r_bus1_p1;
  assign es.bpu_es_bus2 = r_bus2_p1;
  assign es.redirect    = r_redir_vld_p1;
  assign es.redirect_pc = r_redir_pc_p1;
  assign es.cur_epoch   = r_epoch;
  assign es.cnt_branch  = r_cnt_branch;
  assign es.cnt_mispred = r_cnt_mispred;

endmodule

// File: tb/tb_bpu_es_resolver.sv
// Directed bench for bpu_es_resolver with hand-computed expected bus words.
module tb_bpu_es_resolver;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bpu_es_resolver_if #(.EPOCH_W(2), .CNT_W(32)) bif ();
  bpu_es_resolver #(.EPOCH_W(2), .CNT_W(32)) dut (.clk(clk), .reset(reset), .es(bif));

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic f, input logic ex, input logic et,
                                     input logic [31:0] pc, input logic mj, input logic nj,
                                     input logic pf, input logic [31:0] rt, input logic [1:0] jt);
    return {f, ex, et, pc, mj, nj, pf, rt, jt};
  endfunction

  task automatic l1(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                    input logic [31:0] tgt, input logic [1:0] jt, input logic ex, input logic et,
                    input logic ptk, input logic [31:0] ptgt, input logic [1:0] ep);
    bif.l1_valid = v; bif.l1_pc = pc; bif.l1_is_br = br; bif.l1_taken = tk;
    bif.l1_target = tgt; bif.l1_jtype = jt; bif.l1_excp = ex; bif.l1_etrn = et;
    bif.l1_pred_taken = ptk; bif.l1_pred_target = ptgt; bif.l1_epoch = ep;
  endtask

  task automatic l2(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                    input logic [31:0] tgt, input logic [1:0] jt, input logic ex, input logic et,
                    input logic ptk, input logic [31:0] ptgt, input logic [1:0] ep);
    bif.l2_valid = v; bif.l2_pc = pc; bif.l2_is_br = br; bif.l2_taken = tk;
    bif.l2_target = tgt; bif.l2_jtype = jt; bif.l2_excp = ex; bif.l2_etrn = et;
    bif.l2_pred_taken = ptk; bif.l2_pred_target = ptgt; bif.l2_epoch = ep;
  endtask

  task automatic clr();
    l1(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    l2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bif.es_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic rd, input logic [1:0] ep,
                           input logic [31:0] cb, input logic [31:0] cm);
    chk({tag, ".redirect"}, {71'd0, bif.redirect}, {71'd0, rd});
    chk({tag, ".epoch"},    {70'd0, bif.cur_epoch}, {70'd0, ep});
    chk({tag, ".cnt_br"},   {40'd0, bif.cnt_branch}, {40'd0, cb});
    chk({tag, ".cnt_mis"},  {40'd0, bif.cnt_mispred}, {40'd0, cm});
  endtask

  initial begin
    logic [31:0] pc;
    logic [1:0]  ep;
    reset = 1'b1;
    clr();
    step(); step();
    chk("rst.bus1", bif.bpu_es_bus1, 72'd0);
    chk("rst.bus2", bif.bpu_es_bus2, 72'd0);
    chk("rst.rpc", {40'd0, bif.redirect_pc}, 72'd0);
    chk_state("rst", 0, 0, 0, 0);

    // Correctly predicted taken branch
    reset = 1'b0;
    l1(1, 32'h1c000010, 1, 1, 32'h1c000100, 0, 0, 0, 1, 32'h1c000100, 0);
    step();
    chk("t1.bus1", bif.bpu_es_bus1, mk(0, 0, 0, 32'h1c000010, 1, 1, 0, 32'h1c000100, 0));
    chk("t1.bus2", bif.bpu_es_bus2, 72'd0);
    chk_state("t1", 0, 0, 1, 0);

    // Predicted taken, actually not taken: redirect to pc+4
    l1(1, 32'h1c000020, 1, 0, 32'h1c000080, 0, 0, 0, 1, 32'h1c000080, 0);
    step();
    chk("t2.bus1", bif.bpu_es_bus1, mk(1, 0, 0, 32'h1c000020, 1, 0, 1, 32'h1c000080, 0));
    chk("t2.rpc", {40'd0, bif.redirect_pc}, {40'd0, 32'h1c000024});
    chk_state("t2", 1, 1, 2, 1);

    // Stale-epoch lane is dropped
    l1(1, 32'h1c000028, 1, 1, 32'h1c000500, 0, 0, 0, 0, 0, 0);
    step();
    chk("t4.bus1", bif.bpu_es_bus1, 72'd0);
    chk("t4.bus2", bif.bpu_es_bus2, 72'd0);
    chk_state("t4", 0, 1, 2, 1);

    // Both lanes mispredict: lane1 wins, lane2 squashed
    l1(1, 32'h1c000030, 1, 1, 32'h1c000200, 1, 0, 0, 0, 32'h1c000034, 1);
    l2(1, 32'h1c000034, 1, 0, 32'h1c000600, 0, 0, 0, 1, 32'h1c000600, 1);
    step();
    chk("t3.bus1", bif.bpu_es_bus1, mk(1, 0, 0, 32'h1c000030, 1, 1, 1, 32'h1c000200, 1));
    chk("t3.bus2", bif.bpu_es_bus2, 72'd0);
    chk("t3.rpc", {40'd0, bif.redirect_pc}, {40'd0, 32'h1c000200});
    chk_state("t3", 1, 2, 3, 2);

    // Lane1 correct, lane2 target mispredict
    l1(1, 32'h1c000040, 1, 0, 32'h1c000900, 0, 0, 0, 0, 32'h1c000900, 2);
    l2(1, 32'h1c000044, 1, 1, 32'h1c000300, 2, 0, 0, 1, 32'h1c000304, 2);
    step();
    chk("l2m.bus1", bif.bpu_es_bus1, mk(0, 0, 0, 32'h1c000040, 1, 0, 0, 32'h1c000900, 0));
    chk("l2m.bus2", bif.bpu_es_bus2, mk(1, 0, 0, 32'h1c000044, 1, 1, 1, 32'h1c000300, 2));
    chk("l2m.rpc", {40'd0, bif.redirect_pc}, {40'd0, 32'h1c000300});
    chk_state("l2m", 1, 3, 5, 3);

    // Four back-to-back redirects starting at epoch 3
    clr();
    for (int k = 0; k < 4; k++) begin
      pc = 32'h1c001000 + 32'(16 * k);
      ep = 2'(3 + k);
      l1(1, pc, 1, 0, 32'h1c002000, 2'(k), 0, 0, 1, 32'h1c002000, ep);
      step();
      chk($sformatf("t5.bus1[%0d]", k), bif.bpu_es_bus1,
          mk(1, 0, 0, pc, 1, 0, 1, 32'h1c002000, 2'(k)));
      chk($sformatf("t5.bus2[%0d]", k), bif.bpu_es_bus2, 72'd0);
      chk($sformatf("t5.rpc[%0d]", k), {40'd0, bif.redirect_pc}, {40'd0, pc + 32'd4});
      chk_state($sformatf("t5[%0d]", k), 1, 2'(ep + 2'd1), 32'(6 + k), 32'(4 + k));
    end

    // Exception on lane1, ertn on lane2: copied to bus, never resolved
    l1(1, 32'h1c003000, 1, 1, 32'h1c003100, 0, 1, 0, 0, 32'h0, 3);
    l2(1, 32'h1c003004, 0, 0, 32'h1c003200, 0, 0, 1, 0, 32'h0, 3);
    step();
    chk("exc.bus1", bif.bpu_es_bus1, mk(0, 1, 0, 32'h1c003000, 1, 1, 0, 32'h1c003100, 0));
    chk("exc.bus2", bif.bpu_es_bus2, mk(0, 0, 1, 32'h1c003004, 0, 0, 0, 32'h1c003200, 0));
    chk_state("exc", 0, 3, 9, 7);

    // Stall with mispredicting lanes: outputs idle, state holds
    bif.es_stall = 1'b1;
    l1(1, 32'h1c004000, 1, 1, 32'h1c004100, 0, 0, 0, 0, 32'h0, 3);
    l2(1, 32'h1c004004, 1, 1, 32'h1c004200, 0, 0, 0, 0, 32'h0, 3);
    step();
    chk("stl.bus1", bif.bpu_es_bus1, 72'd0);
    chk("stl.bus2", bif.bpu_es_bus2, 72'd0);
    chk("stl.rpc", {40'd0, bif.redirect_pc}, {40'd0, 32'h1c001034});
    chk_state("stl", 0, 3, 9, 7);

    // Saturation of the branch counter
    bif.es_stall = 1'b0;
    force dut.r_cnt_branch = 32'hFFFF_FFFF;
    #1;
    release dut.r_cnt_branch;
    l1(1, 32'h1c005000, 1, 1, 32'h1c005100, 0, 0, 0, 1, 32'h1c005100, 3);
    l2(1, 32'h1c005004, 1, 0, 32'h1c005200, 0, 0, 0, 0, 32'h0, 3);
    step();
    chk("sat.bus2", bif.bpu_es_bus2, mk(0, 0, 0, 32'h1c005004, 1, 0, 0, 32'h1c005200, 0));
    chk_state("sat", 0, 3, 32'hFFFF_FFFF, 7);

    // Reset mid-stream with a mispredicting lane in the reset cycle
    reset = 1'b1;
    l1(1, 32'h1c006000, 1, 1, 32'h1c006100, 0, 0, 0, 0, 32'h0, 3);
    step();
    chk("mrst.bus1", bif.bpu_es_bus1, 72'd0);
    chk("mrst.rpc", {40'd0, bif.redirect_pc}, 72'd0);
    chk_state("mrst", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
